// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - ramping-rate LED pattern generator (rotate/bounce/LFSR)
// Optional PWM dimming of the LED outputs when LED_PATTERN_PWM_EN is defined.
module led_pattern_engine #(
   parameter int unsigned NUM_LEDS  = 4,
   parameter int unsigned ACC_WIDTH = 31,
   parameter int unsigned THRESHOLD = 100000000,
   parameter int unsigned INC_START = 1,
   parameter int unsigned INC_MAX   = 20000,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef LED_PATTERN_PWM_EN
   ,
   parameter int unsigned PWM_DUTY  = 64
`endif
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic [1:0]          i_Mode,
   input  logic                i_Hold,
   output logic [NUM_LEDS-1:0] o_LED,
   output logic                o_Step,
   output logic                o_Ramp_Wrap
);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   localparam logic [ACC_WIDTH-1:0] THRESH_C    = ACC_WIDTH'(THRESHOLD);
   localparam logic [ACC_WIDTH-1:0] INC_START_C = ACC_WIDTH'(INC_START);
   localparam logic [ACC_WIDTH-1:0] INC_MAX_C   = ACC_WIDTH'(INC_MAX);
   localparam logic [ACC_WIDTH-1:0] ACC_ONE_C   = ACC_WIDTH'(1);
   localparam logic [NUM_LEDS-1:0]  ONE_HOT_C   = NUM_LEDS'(1);

   logic [ACC_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d, inc_next;
   logic [1:0]           mode_q, mode_d;
   dir_e                 dir_q, dir_d;
   logic [15:0]          lfsr_q, lfsr_d, lfsr_step;
   logic [NUM_LEDS-1:0]  pat_q, pat_d;
   logic                 step_q, step_d, wrap_q, wrap_d;

   assign inc_next  = inc_q + ACC_ONE_C;
   assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      acc_d  = acc_q;
      inc_d  = inc_q;
      mode_d = mode_q;
      dir_d  = dir_q;
      lfsr_d = lfsr_q;
      pat_d  = pat_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (!i_Hold) begin
         if (acc_q > THRESH_C) begin
            acc_d  = '0;
            step_d = 1'b1;
            if (inc_next > INC_MAX_C) begin
               inc_d  = INC_START_C;
               wrap_d = 1'b1;
            end else begin
               inc_d = inc_next;
            end
            mode_d = i_Mode;
            // A mode change only loads the entry pattern; stepping resumes next advance.
            if (i_Mode != mode_q) begin
               if (i_Mode == 2'd3) begin
                  pat_d = lfsr_q[NUM_LEDS-1:0];
               end else begin
                  pat_d = ONE_HOT_C;
                  dir_d = DIR_UP;
               end
            end else begin
               case (mode_q)
                  2'd0: pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
                  2'd1: pat_d = {pat_q[0], pat_q[NUM_LEDS-1:1]};
                  2'd2: begin
                     if (dir_q == DIR_UP) begin
                        if (pat_q[NUM_LEDS-1]) begin
                           dir_d = DIR_DOWN;
                           pat_d = pat_q >> 1;
                        end else begin
                           pat_d = pat_q << 1;
                        end
                     end else begin
                        if (pat_q[0]) begin
                           dir_d = DIR_UP;
                           pat_d = pat_q << 1;
                        end else begin
                           pat_d = pat_q >> 1;
                        end
                     end
                  end
                  default: begin
                     lfsr_d = lfsr_step;
                     pat_d  = lfsr_step[NUM_LEDS-1:0];
                  end
               endcase
            end
         end else begin
            acc_d = acc_q + inc_q;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         acc_q  <= '0;
         inc_q  <= INC_START_C;
         mode_q <= 2'd0;
         dir_q  <= DIR_UP;
         lfsr_q <= LFSR_SEED;
         pat_q  <= ONE_HOT_C;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         inc_q  <= inc_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
         lfsr_q <= lfsr_d;
         pat_q  <= pat_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_Step      = step_q;
   assign o_Ramp_Wrap = wrap_q;

`ifdef LED_PATTERN_PWM_EN
   localparam logic [7:0] PWM_DUTY_C = 8'(PWM_DUTY);
   logic [7:0] pwm_cnt_q;

   // Free-running so dimming continues while the pattern is held.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) pwm_cnt_q <= 8'd0;
      else          pwm_cnt_q <= pwm_cnt_q + 8'd1;
   end

   assign o_LED = pat_q & {NUM_LEDS{pwm_cnt_q < PWM_DUTY_C}};
`else
   assign o_LED = pat_q;
`endif

endmodule
